// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor:
//   - state_e          : FSM encodings (IDLE=0, RUN=1, DONE=2)
//   - SERSUB_WIDTH_DEF : default operand width
//   - sub_overflow()   : signed-overflow rule for a - b from the three MSBs
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned SERSUB_WIDTH_DEF = 32'd8;

  // a - b overflows (two's complement) only when the operand signs differ
  // and the result sign differs from the minuend sign.
  function automatic logic sub_overflow(input logic a_msb,
                                        input logic b_msb,
                                        input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// Combinational 1-bit subtractor cell computing x - y - bin.
// Ports:
//   x    in  1  minuend bit
//   y    in  1  subtrahend bit
//   bin  in  1  borrow in from the less significant bit
//   d    out 1  difference bit
//   bout out 1  borrow out to the more significant bit
// -----------------------------------------------------------------------------
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference is the plain parity; a borrow is produced when y exceeds x,
  // or when the bits are equal and a borrow is already pending.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor computing a - b, LSB first, one bit per
// clock, using a single full_subtractor cell plus a borrow flop.
// Handshake: start is sampled in IDLE; busy is high in RUN and DONE; done is
// a one-cycle pulse coincident with diff/borrow_out becoming valid.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   start      in   1      request, sampled only when idle
//   a          in   WIDTH  minuend, captured on accepted start
//   b          in   WIDTH  subtrahend, captured on accepted start
//   busy       out  1      operation in progress
//   done       out  1      one-cycle result-valid pulse
//   diff       out  WIDTH  a - b modulo 2^WIDTH (held until next result)
//   borrow_out out  1      a < b unsigned (held with diff)
//   overflow   out  1      signed overflow; only with SERSUB_OVERFLOW_EN
// Build option: define SERSUB_OVERFLOW_EN to add the overflow port and the
// operand MSB capture flops behind it.
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = SERSUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERSUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             borrow_out
);

  localparam int unsigned    CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_out_q, borrow_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SERSUB_OVERFLOW_EN
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               overflow_q, overflow_d;
`endif

  logic               bit_d_s;
  logic               bit_bout_s;

  full_subtractor u_cell (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .bin  (borrow_q),
    .d    (bit_d_s),
    .bout (bit_bout_s)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d      = state_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    res_d        = res_q;
    cnt_d        = cnt_q;
    borrow_d     = borrow_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
`ifdef SERSUB_OVERFLOW_EN
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    overflow_d   = overflow_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          a_sr_d   = a;
          b_sr_d   = b;
          res_d    = '0;
          cnt_d    = '0;
          borrow_d = 1'b0;
          busy_d   = 1'b1;
`ifdef SERSUB_OVERFLOW_EN
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
        end else begin
          busy_d = 1'b0;
        end
      end

      ST_RUN: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        res_d    = {bit_d_s, res_q[WIDTH-1:1]};
        borrow_d = bit_bout_s;
        busy_d   = 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the result on this edge so it is valid
          // together with the done pulse in the DONE cycle.
          state_d      = ST_DONE;
          cnt_d        = '0;
          diff_d       = {bit_d_s, res_q[WIDTH-1:1]};
          borrow_out_d = bit_bout_s;
          done_d       = 1'b1;
`ifdef SERSUB_OVERFLOW_EN
          overflow_d   = sub_overflow(a_msb_q, b_msb_q, bit_d_s);
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SERSUB_OVERFLOW_EN
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      overflow_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      res_q        <= res_d;
      cnt_q        <= cnt_d;
      borrow_q     <= borrow_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef SERSUB_OVERFLOW_EN
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      overflow_q   <= overflow_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
`ifdef SERSUB_OVERFLOW_EN
  assign overflow   = overflow_q;
`endif

endmodule
